crc_frame_sequencer: RTL

- Byte-stream framer that drives one `parallel_crc_ccitt` engine (CRC-16/CCITT, poly 0x1021, MSB-first, 8 bits per enable).
- Passes each payload byte downstream and updates the engine, then appends the 2-byte CRC (high byte first) after the byte flagged last.
- Sits between a packet source and a serial/link transmitter. Also reports per-frame CRC and frame count to status logic.

---
 rtl/crc_pkg.sv | 30 +++
 rtl/parallel_crc_ccitt.sv | 38 +++
 rtl/crc_frame_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared CRC-16/CCITT constants, framer state encoding and the byte-wide
// CRC update used by the parallel engine.
package crc_pkg;

  localparam logic [15:0] CRC_CCITT_POLY       = 16'h1021;
  localparam logic [15:0] CRC_CCITT_FALSE_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_XMODEM_INIT      = 16'h0000;

  typedef enum logic [1:0] {
    ST_DATA,
    ST_CRC_HI,
    ST_CRC_LO
  } crc_state_e;

  // Absorbs one byte MSB-first; unrolls to a pure XOR network.
  function automatic logic [15:0] crc_ccitt_byte(input logic [15:0] crc,
                                                 input logic [7:0]  x);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ x[i]) begin
        c = {c[14:0], 1'b0} ^ CRC_CCITT_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/parallel_crc_ccitt.sv
// CRC-16/CCITT engine absorbing 8 bits per enable; init has priority over
// enable and the result is visible after the clock edge.
module parallel_crc_ccitt
  import crc_pkg::*;
#(
  parameter logic [15:0] INIT_VALUE = CRC_CCITT_FALSE_INIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        enable,
  input  logic [7:0]  x,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = INIT_VALUE;
    end else if (enable) begin
      crc_d = crc_ccitt_byte(crc_q, x);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= INIT_VALUE;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc_frame_sequencer.sv
// Byte-stream framer: forwards payload bytes through a one-deep output slot and
// appends the CRC-16 (high byte first) after the last payload byte.
module crc_frame_sequencer
  import crc_pkg::*;
#(
  parameter logic [15:0] INIT_VALUE = CRC_CCITT_FALSE_INIT,
  parameter logic [15:0] XOR_OUT    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [15:0] crc_value,
  output logic        crc_done,
  output logic [15:0] frame_count
);

  crc_state_e  state_q, state_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic [15:0] crc_value_q, crc_value_d;
  logic        crc_done_q, crc_done_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic        slot_free;
  logic        eng_init;
  logic        eng_enable;
  logic        eng_reset;
  logic [15:0] eng_crc;
  logic [15:0] crc_out;

  assign eng_reset = ~reset;
  assign slot_free = ~m_valid_q | m_ready;
  assign crc_out   = eng_crc ^ XOR_OUT;

  parallel_crc_ccitt #(
    .INIT_VALUE(INIT_VALUE)
  ) u_crc (
    .clk   (clk),
    .reset (eng_reset),
    .init  (eng_init),
    .enable(eng_enable),
    .x     (s_data),
    .crc   (eng_crc)
  );

  always_comb begin
    state_d       = state_q;
    m_data_d      = m_data_q;
    m_valid_d     = m_valid_q;
    m_last_d      = m_last_q;
    crc_value_d   = crc_value_q;
    crc_done_d    = 1'b0;
    frame_count_d = frame_count_q;
    s_ready       = 1'b0;
    eng_init      = 1'b0;
    eng_enable    = 1'b0;

    if (clear) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      state_d   = ST_DATA;
      eng_init  = 1'b1;
    end else begin
      // A consumed beat empties the slot unless something reloads it below.
      if (slot_free) begin
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end
      case (state_q)
        ST_DATA: begin
          s_ready = slot_free;
          if (s_valid && slot_free) begin
            m_data_d   = s_data;
            m_valid_d  = 1'b1;
            eng_enable = 1'b1;
            if (s_last) begin
              state_d = ST_CRC_HI;
            end
          end
        end
        ST_CRC_HI: begin
          if (slot_free) begin
            m_data_d  = crc_out[15:8];
            m_valid_d = 1'b1;
            state_d   = ST_CRC_LO;
          end
        end
        ST_CRC_LO: begin
          if (slot_free) begin
            m_data_d      = crc_out[7:0];
            m_valid_d     = 1'b1;
            m_last_d      = 1'b1;
            crc_value_d   = crc_out;
            crc_done_d    = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            eng_init      = 1'b1;
            state_d       = ST_DATA;
          end
        end
        default: state_d = ST_DATA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_DATA;
      m_data_q      <= 8'h00;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      crc_value_q   <= 16'h0000;
      crc_done_q    <= 1'b0;
      frame_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      crc_value_q   <= crc_value_d;
      crc_done_q    <= crc_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign crc_value   = crc_value_q;
  assign crc_done    = crc_done_q;
  assign frame_count = frame_count_q;

endmodule
